capture_ring: RTL and testbench
===============================

# capture_ring

Parametrised multi-channel capture controller for the logic-analyzer datapath. Writes decimated sample words from `NUM_CH` channels into per-channel circular RAMqueue instances on a shared write address. Holds off triggers until the pre-trigger window is full, then stops after a programmable number of post-trigger samples. Signals completion to `cmd_cfg` through `set_capture_done` and exposes the final write pointer, so the read-out logic there can unroll the ring.

## Interface
- `NUM_CH`, 5: number of channels (1..8).
- `DATA_W`, 8: sample width per channel.
- `DEPTH`, 384: entries per RAMqueue (need not be a power of 2).
- `ADDR_W`, `$clog2(DEPTH)`: address width.

Ports (clock and reset first):
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: reset; synchronous, active-high.
- `run`  in  1: capture enable (`TrigCfg` run bit); level.
- `clr_done`  in  1: one-cycle pulse that clears `capture_done`.
- `decimator`  in  4: store 1 of every 2^`decimator` valid samples.
- `trig_pos`  in  `ADDR_W`: post-trigger sample count; values ≥`DEPTH` clamp to `DEPTH`-1.
- `ch_en`  in  `NUM_CH`: per-channel write enable mask.
- `triggered`  in  1: trigger event from trigger logic; a single-cycle pulse is sufficient.
- `smpl_vld`  in  1: a new sample is present on `smpl_data`.
- `smpl_data`  in  `NUM_CH*DATA_W`: channel k occupies bits [k*`DATA_W` +: `DATA_W`].
- `we`  out  `NUM_CH`: registered RAM write enables.
- `waddr`  out  `ADDR_W`: registered shared write address; after a capture, the last-written entry.
- `wdata`  out  `NUM_CH*DATA_W`: registered sample word.
- `armed`  out  1: pre-trigger window full; triggers are now accepted.
- `capture_done`  out  1: level, high from end of capture until `clr_done` or `rst`.
- `set_capture_done`  out  1: one-cycle pulse on entry to DONE.

## Operation
- States:
  - IDLE: waiting for `run`.
  - FILL: writing samples; pre-trigger window not yet full.
  - ARMED: window full; waiting for a trigger.
  - POST: trigger latched; counting post-trigger samples.
  - DONE: capture complete; no writes.
- Transitions:
  - IDLE→FILL on `run`=1. Clears the decimation counter, fill counter and post counter. `waddr` is not cleared.
  - FILL→ARMED after `DEPTH`−`trig_pos` stored samples.
  - ARMED→POST on `triggered`. A trigger in FILL or IDLE is ignored.
  - POST→DONE when the post count equals clamped `trig_pos`, evaluated after each stored sample. If `trig_pos`=0, POST→DONE on the next cycle with no further writes.
  - DONE→IDLE on `clr_done`.
  - Any state except DONE → IDLE when `run`=0. Any sample write in flight completes.
- Storing a sample:
  - A stored sample is an `smpl_vld` cycle on which the decimation counter equals 0.
  - The counter is 15 bits and counts modulo 2^`decimator`. `decimator`=0 stores every valid sample.
  - Samples are stored only in FILL, ARMED and POST.
- Store effects:
  - `wdata` ← `smpl_data`.
  - `we` ← `ch_en`.
  - `waddr` ← `waddr`+1, wrapping `DEPTH`−1→0. The first store after reset writes address 0.
- A trigger arriving on the same cycle as a store in ARMED: the sample is stored as pre-trigger. The post count starts at 0 and counts subsequent stores only.
- `decimator`, `trig_pos` and `ch_en` are sampled when `run` rises and held for the capture.
- `clr_done` and `run`=1 together in DONE: clear to IDLE this cycle; FILL on the next cycle.

## Timing
- Reset values: state IDLE, `we`=0, `waddr`=0, `wdata`=0, `armed`=0, `capture_done`=0, `set_capture_done`=0, and all counters 0.
- Write latency: one cycle. The qualifying `smpl_vld` on cycle n produces `we`/`waddr`/`wdata` on cycle n+1, with `we` high for exactly one cycle.
- `waddr` holds its value between writes.
- `armed` rises the cycle after the store that completes the fill, and falls on leaving ARMED.
- `set_capture_done` and `capture_done` rise in the cycle after the final post-trigger store.
- Reset asserted mid-capture forces all outputs to their reset values on the next edge. Any pending write is dropped.
- Throughput: one store per cycle.

## Structure
- Package `capture_pkg`:
  - state enum `cap_state_t`.
  - constants `CAP_DEC_W`=4 and `CAP_DECCNT_W`=15.
- Sub-module `ring_addr_ctr`:
  - parameter `DEPTH`.
  - ports: `inc`, `clr`, `addr`, `wrap`.
  - wrapping counter used for `waddr`; reused by `cmd_cfg` for `addr_ptr`.
- Counter widths:
  - fill counter and post counter: `ADDR_W`+1, so they cannot overflow at `DEPTH`.

## Test plan
Scenarios 1–4 and 6 use `DEPTH`=8, `NUM_CH`=5.
1. `decimator`=0, `trig_pos`=3, `smpl_vld` every cycle, `triggered` pulsed 10 cycles after `run`. Expect `armed` after 5 stores; 3 post stores; `set_capture_done` pulse; `waddr` wrapped 7→0.
2. `decimator`=2, `smpl_vld` every cycle. Expect `we` on every 4th cycle only; `wdata` equal to `smpl_data` of samples 0, 4, 8, ….
3. `triggered` held high from `run` onward, `trig_pos`=6. Expect no POST entry until 2 stores are done; DONE after 6 further stores.
4. `trig_pos`=0, trigger while ARMED. Expect DONE one cycle later with zero post writes; `capture_done` held until `clr_done`, then IDLE.
5. `DEPTH`=384, `ch_en`=5'b10101, 500 stores. Expect `we` always 10101; `waddr` 383→0 wrap; no address ≥384 ever issued.
6. `rst` asserted in POST with `smpl_vld` high. Expect next cycle: `we`=0, `waddr`=0, `capture_done`=0, state IDLE.

Source files
------------

// File: rtl/capture_ring_pkg.sv
// Shared types and constants for the capture ring controller.
package capture_pkg;

  localparam int CAP_DEC_W    = 4;
  localparam int CAP_DECCNT_W = 15;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_FILL,
    CAP_ARMED,
    CAP_POST,
    CAP_DONE
  } cap_state_t;

  // Modulus mask for the decimation counter. A shift of 15 drops out of the
  // 15-bit word, so the subtraction yields all ones (full-width counter).
  function automatic logic [CAP_DECCNT_W-1:0] dec_mask(input logic [CAP_DEC_W-1:0] dec);
    return (CAP_DECCNT_W'(1) << dec) - CAP_DECCNT_W'(1);
  endfunction

endpackage

// File: rtl/capture_ring_if.sv
// Control, sample and RAM-write bundle between the trigger/sample side and
// the capture controller.
interface capture_ring_if
  import capture_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);

  logic                       run;
  logic                       clr_done;
  logic [CAP_DEC_W-1:0]       decimator;
  logic [ADDR_W-1:0]          trig_pos;
  logic [NUM_CH-1:0]          ch_en;
  logic                       triggered;
  logic                       smpl_vld;
  logic [NUM_CH*DATA_W-1:0]   smpl_data;

  logic [NUM_CH-1:0]          we;
  logic [ADDR_W-1:0]          waddr;
  logic [NUM_CH*DATA_W-1:0]   wdata;
  logic                       armed;
  logic                       capture_done;
  logic                       set_capture_done;

  modport master (
    output run, clr_done, decimator, trig_pos, ch_en, triggered, smpl_vld, smpl_data,
    input  we, waddr, wdata, armed, capture_done, set_capture_done
  );

  modport slave (
    input  run, clr_done, decimator, trig_pos, ch_en, triggered, smpl_vld, smpl_data,
    output we, waddr, wdata, armed, capture_done, set_capture_done
  );

endinterface

// File: rtl/capture_ring_ring_addr_ctr.sv
// Wrapping address counter 0..DEPTH-1; DEPTH need not be a power of two.
module ring_addr_ctr #(
  parameter int DEPTH  = 384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              at_last;

  assign at_last = (addr_q == LAST_C);
  assign wrap    = inc && at_last;
  assign addr    = addr_q;

  // Next pointer: clear wins over increment, increment wraps at the last entry.
  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (inc) begin
      addr_d = at_last ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/capture_ring.sv
// Multi-channel capture controller: stores decimated samples into per-channel
// ring RAMs on a shared write address, arms after the pre-trigger window is
// full and stops a programmable number of stores after the trigger.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   CAP_IDLE  | waiting for run
//   CAP_FILL  | storing, pre-trigger window not yet full
//   CAP_ARMED | window full, waiting for a trigger
//   CAP_POST  | trigger latched, counting post-trigger stores
//   CAP_DONE  | capture complete, no writes until clr_done
module capture_ring
  import capture_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  capture_ring_if.slave  cap_if
);

  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  cap_state_t                state_q, state_d;
  logic [CAP_DECCNT_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0]          fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]          post_cnt_q, post_cnt_d;
  logic [CAP_DEC_W-1:0]      cfg_dec_q, cfg_dec_d;
  logic [ADDR_W-1:0]         cfg_tp_q, cfg_tp_d;
  logic [NUM_CH-1:0]         cfg_ch_en_q, cfg_ch_en_d;

  logic [NUM_CH-1:0]         we_q;
  logic [ADDR_W-1:0]         waddr_q;
  logic [NUM_CH*DATA_W-1:0]  wdata_q;
  logic                      armed_q;
  logic                      capture_done_q;
  logic                      set_capture_done_q;

  logic [ADDR_W-1:0]         trig_pos_clamped;
  logic [CNT_W-1:0]          post_target;
  logic [CNT_W-1:0]          fill_target;
  logic                      capturing;
  logic                      smpl_take;
  logic                      post_full;
  logic                      store;
  logic [ADDR_W-1:0]         wr_ptr;
  logic                      wr_ptr_wrap_unused;

  assign trig_pos_clamped = ({1'b0, cap_if.trig_pos} >= DEPTH_C) ? LAST_C : cap_if.trig_pos;
  assign post_target      = {1'b0, cfg_tp_q};
  assign fill_target      = DEPTH_C - post_target;

  // A store is a valid sample landing on decimation phase 0 while capturing.
  // With a zero post count the POST state must not write at all.
  assign capturing = cap_if.run &&
                     (state_q inside {CAP_FILL, CAP_ARMED, CAP_POST});
  assign smpl_take = capturing && cap_if.smpl_vld;
  assign post_full = (state_q == CAP_POST) && (post_cnt_q == post_target);
  assign store     = smpl_take && (dec_cnt_q == '0) && !post_full;

  // Shared write pointer holds the next address to write; waddr reports the
  // entry actually written, so the first store after reset lands on 0.
  ring_addr_ctr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (store),
    .clr  (1'b0),
    .addr (wr_ptr),
    .wrap (wr_ptr_wrap_unused)
  );

  // Next-state, counter and configuration-latch logic.
  always_comb begin
    state_d     = state_q;
    dec_cnt_d   = dec_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    cfg_dec_d   = cfg_dec_q;
    cfg_tp_d    = cfg_tp_q;
    cfg_ch_en_d = cfg_ch_en_q;

    if (smpl_take) begin
      dec_cnt_d = (dec_cnt_q + CAP_DECCNT_W'(1)) & dec_mask(cfg_dec_q);
    end

    case (state_q)
      CAP_IDLE: begin
        if (cap_if.run) begin
          state_d     = CAP_FILL;
          dec_cnt_d   = '0;
          fill_cnt_d  = '0;
          post_cnt_d  = '0;
          cfg_dec_d   = cap_if.decimator;
          cfg_tp_d    = trig_pos_clamped;
          cfg_ch_en_d = cap_if.ch_en;
        end
      end
      CAP_FILL: begin
        if (!cap_if.run) begin
          state_d = CAP_IDLE;
        end else if (store) begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          if (fill_cnt_d == fill_target) begin
            state_d = CAP_ARMED;
          end
        end
      end
      CAP_ARMED: begin
        // A store on the trigger cycle is still pre-trigger data.
        if (!cap_if.run) begin
          state_d = CAP_IDLE;
        end else if (cap_if.triggered) begin
          state_d = CAP_POST;
        end
      end
      CAP_POST: begin
        if (!cap_if.run) begin
          state_d = CAP_IDLE;
        end else if (post_full) begin
          state_d = CAP_DONE;
        end else if (store) begin
          post_cnt_d = post_cnt_q + CNT_W'(1);
          if (post_cnt_d == post_target) begin
            state_d = CAP_DONE;
          end
        end
      end
      CAP_DONE: begin
        if (cap_if.clr_done) begin
          state_d = CAP_IDLE;
        end
      end
      default: begin
        state_d = CAP_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and configuration captured at the start of a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q   <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      cfg_dec_q   <= '0;
      cfg_tp_q    <= '0;
      cfg_ch_en_q <= '0;
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      cfg_dec_q   <= cfg_dec_d;
      cfg_tp_q    <= cfg_tp_d;
      cfg_ch_en_q <= cfg_ch_en_d;
    end
  end

  // Registered RAM write port and status flags; reset drops a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q               <= '0;
      waddr_q            <= '0;
      wdata_q            <= '0;
      armed_q            <= 1'b0;
      capture_done_q     <= 1'b0;
      set_capture_done_q <= 1'b0;
    end else begin
      we_q <= store ? cfg_ch_en_q : '0;
      if (store) begin
        waddr_q <= wr_ptr;
        wdata_q <= cap_if.smpl_data;
      end
      armed_q            <= (state_d == CAP_ARMED);
      capture_done_q     <= (state_d == CAP_DONE);
      set_capture_done_q <= (state_d == CAP_DONE) && (state_q != CAP_DONE);
    end
  end

  assign cap_if.we               = we_q;
  assign cap_if.waddr            = waddr_q;
  assign cap_if.wdata            = wdata_q;
  assign cap_if.armed            = armed_q;
  assign cap_if.capture_done     = capture_done_q;
  assign cap_if.set_capture_done = set_capture_done_q;

endmodule

// File: tb/tb_capture_ring.sv
// Bench for capture_ring: a directed vector table, hand-written corner
// sequences and a randomized run checked cycle by cycle against a reference
// model, plus a long capture on a full-size instance.
module tb_capture_ring;

  localparam int NC    = 5;
  localparam int DW    = 8;
  localparam int D8    = 8;
  localparam int AW8   = 3;
  localparam int D384  = 384;
  localparam int AW384 = 9;

  logic clk = 1'b0;
  logic rst8;
  logic rst384;

  always #5 clk = ~clk;

  capture_ring_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW8))   if8 ();
  capture_ring_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW384)) if384 ();

  capture_ring #(.NUM_CH(NC), .DATA_W(DW), .DEPTH(D8), .ADDR_W(AW8)) dut8 (
    .clk    (clk),
    .rst    (rst8),
    .cap_if (if8.slave)
  );

  capture_ring #(.NUM_CH(NC), .DATA_W(DW), .DEPTH(D384), .ADDR_W(AW384)) dut384 (
    .clk    (clk),
    .rst    (rst384),
    .cap_if (if384.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*DW-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i * 7 + 48);
    return {NC{b}};
  endfunction

  // ---------------- reference model for the DEPTH=8 instance ----------------
  // Tracks the capture as a count of valid samples since run, stores made in
  // the pre-trigger and post-trigger phases, and the next ring slot.
  int               m_phase;   // 0 idle, 1 filling, 2 armed, 3 post, 4 done
  int               m_dec, m_tp, m_nsmp, m_pre, m_post, m_next;
  logic [NC-1:0]    m_chen;
  logic [NC-1:0]    e_we;
  int               e_waddr;
  logic [NC*DW-1:0] e_wdata;
  bit               e_armed, e_done, e_set;

  task automatic model_step();
    int nph;
    bit st;
    if (rst8) begin
      m_phase = 0; m_dec = 0; m_tp = 0; m_chen = '0;
      m_nsmp = 0; m_pre = 0; m_post = 0; m_next = 0;
      e_we = '0; e_waddr = 0; e_wdata = '0;
      e_armed = 0; e_done = 0; e_set = 0;
      return;
    end
    nph = m_phase;
    st  = 0;
    if (m_phase == 0) begin
      if (if8.run) begin
        nph    = 1;
        m_dec  = int'(if8.decimator);
        m_tp   = (int'(if8.trig_pos) >= D8) ? D8 - 1 : int'(if8.trig_pos);
        m_chen = if8.ch_en;
        m_nsmp = 0; m_pre = 0; m_post = 0;
      end
    end else if (m_phase == 4) begin
      if (if8.clr_done) nph = 0;
    end else if (!if8.run) begin
      nph = 0;
    end else begin
      if (if8.smpl_vld) begin
        st = ((m_nsmp % (1 << m_dec)) == 0);
        m_nsmp++;
      end
      if (m_phase == 1) begin
        if (st) begin
          m_pre++;
          if (m_pre == D8 - m_tp) nph = 2;
        end
      end else if (m_phase == 2) begin
        if (if8.triggered) nph = 3;
      end else begin
        if (m_tp == 0) begin
          st  = 0;
          nph = 4;
        end else if (st) begin
          m_post++;
          if (m_post == m_tp) nph = 4;
        end
      end
    end
    e_we = st ? m_chen : '0;
    if (st) begin
      e_waddr = m_next;
      m_next  = (m_next + 1) % D8;
      e_wdata = if8.smpl_data;
    end
    e_armed = (nph == 2);
    e_done  = (nph == 4);
    e_set   = (nph == 4) && (m_phase != 4);
    m_phase = nph;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("model", 64'({if8.we, if8.waddr, if8.wdata, if8.armed, if8.capture_done, if8.set_capture_done}),
                 64'({e_we, 3'(e_waddr), e_wdata, e_armed, e_done, e_set}));
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, run, clr, trig, vld;
    bit e_we;
    int e_waddr;
    int e_wd;      // row whose sample word is expected on wdata, -1 for zero
    bit e_armed, e_done, e_set;
  } vec_t;

  vec_t tbl[15];

  task automatic go_idle();
    if8.run = 0; if8.clr_done = 1; if8.triggered = 0; if8.smpl_vld = 0;
    tick();
    if8.clr_done = 0;
    tick();
  endtask

  int n_st, armed_at, fall_at, post_st, n_set, prev_addr;
  bit wrapped;
  logic [NC*DW-1:0] d;

  initial begin
    rst8 = 1; rst384 = 1;
    if8.run = 0; if8.clr_done = 0; if8.decimator = '0; if8.trig_pos = '0; if8.ch_en = '0;
    if8.triggered = 0; if8.smpl_vld = 0; if8.smpl_data = '0;
    if384.run = 0; if384.clr_done = 0; if384.decimator = '0; if384.trig_pos = '0; if384.ch_en = '0;
    if384.triggered = 0; if384.smpl_vld = 0; if384.smpl_data = '0;

    // trig_pos=6 on depth 8: two fill stores, trigger held high throughout
    //          rst run clr trg vld  we addr wd  arm done set
    tbl[0]  = '{1, 0, 0, 0, 0,   0, 0, -1,  0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 1,   0, 0, -1,  0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 1,   1, 0,  2,  0, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 1,   1, 1,  3,  1, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 1,   1, 2,  4,  0, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 1,   1, 3,  5,  0, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 1,   1, 4,  6,  0, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 1,   1, 5,  7,  0, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 1,   1, 6,  8,  0, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 1,   1, 7,  9,  0, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 1,   1, 0, 10,  0, 1, 1};
    tbl[11] = '{0, 1, 0, 1, 1,   0, 0, 10,  0, 1, 0};
    tbl[12] = '{0, 1, 1, 0, 1,   0, 0, 10,  0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 1,   0, 0, 10,  0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 1,   1, 1, 14,  0, 0, 0};

    if8.decimator = 4'd0; if8.trig_pos = 3'd6; if8.ch_en = 5'h1F;
    for (int i = 0; i < 15; i++) begin
      rst8 = tbl[i].rst; if8.run = tbl[i].run; if8.clr_done = tbl[i].clr;
      if8.triggered = tbl[i].trig; if8.smpl_vld = tbl[i].vld; if8.smpl_data = pat(i);
      tick();
      if (i == 0) rst384 = 0;
      chk($sformatf("tbl%0d_we", i), 64'(if8.we), 64'(tbl[i].e_we ? 5'h1F : 5'h00));
      chk($sformatf("tbl%0d_waddr", i), 64'(if8.waddr), 64'(tbl[i].e_waddr));
      chk($sformatf("tbl%0d_wdata", i), 64'(if8.wdata), 64'(tbl[i].e_wd < 0 ? '0 : pat(tbl[i].e_wd)));
      chk($sformatf("tbl%0d_flags", i), 64'({if8.armed, if8.capture_done, if8.set_capture_done}),
          64'({tbl[i].e_armed, tbl[i].e_done, tbl[i].e_set}));
    end

    // decimator=2: only samples 0, 4, 8, ... are written
    go_idle();
    if8.decimator = 4'd2; if8.trig_pos = 3'd3; if8.ch_en = 5'h1F;
    if8.smpl_vld = 1; if8.run = 1; if8.smpl_data = pat(99);
    tick();
    for (int s = 0; s < 12; s++) begin
      if8.smpl_data = pat(s);
      tick();
      if (s % 4 == 0) begin
        chk($sformatf("dec_store%0d", s), 64'({if8.we, if8.wdata}), 64'({5'h1F, pat(s)}));
      end else begin
        chk($sformatf("dec_skip%0d", s), 64'(if8.we), 64'(0));
      end
    end

    // trig_pos=3, trigger pulsed 10 cycles after run
    go_idle();
    if8.decimator = 4'd0; if8.trig_pos = 3'd3; if8.ch_en = 5'h1F;
    if8.smpl_vld = 1; if8.run = 1;
    n_st = 0; armed_at = -1; fall_at = -1; post_st = 0; n_set = 0; prev_addr = -1; wrapped = 0;
    for (int c = 0; c < 20; c++) begin
      if8.triggered = (c == 10);
      if8.smpl_data = pat(c);
      tick();
      if (if8.we != 0) begin
        n_st++;
        if (prev_addr == 7 && if8.waddr == 0) wrapped = 1;
        prev_addr = int'(if8.waddr);
        if (fall_at >= 0) post_st++;
      end
      if (if8.armed && armed_at < 0) armed_at = n_st;
      if (!if8.armed && armed_at >= 0 && fall_at < 0) fall_at = c;
      if (if8.set_capture_done) n_set++;
    end
    if8.triggered = 0;
    chk("s1_armed_after", 64'(armed_at), 64'(5));
    chk("s1_post_stores", 64'(post_st), 64'(3));
    chk("s1_total_stores", 64'(n_st), 64'(13));
    chk("s1_set_pulses", 64'(n_set), 64'(1));
    chk("s1_wrapped", 64'(wrapped), 64'(1));
    chk("s1_done_level", 64'(if8.capture_done), 64'(1));

    // trig_pos=0: DONE one cycle after trigger, no post writes
    go_idle();
    if8.decimator = 4'd0; if8.trig_pos = 3'd0; if8.ch_en = 5'h1F;
    if8.smpl_vld = 1; if8.run = 1;
    tick();
    n_st = 0;
    for (int c = 0; c < 20 && !if8.armed; c++) begin
      tick();
      if (if8.we != 0) n_st++;
    end
    chk("s4_armed", 64'(if8.armed), 64'(1));
    chk("s4_fill_stores", 64'(n_st), 64'(8));
    if8.triggered = 1;
    tick();
    if8.triggered = 0;
    chk("s4_trig_cycle", 64'({if8.we, if8.armed, if8.capture_done}), 64'({5'h1F, 1'b0, 1'b0}));
    tick();
    chk("s4_done_entry", 64'({if8.we, if8.capture_done, if8.set_capture_done}), 64'({5'h00, 1'b1, 1'b1}));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s4_done_hold", 64'({if8.we, if8.capture_done, if8.set_capture_done}), 64'({5'h00, 1'b1, 1'b0}));
    end
    if8.clr_done = 1;
    tick();
    if8.clr_done = 0;
    chk("s4_clr", 64'({if8.we, if8.capture_done}), 64'(0));
    tick();
    chk("s4_idle_no_write", 64'(if8.we), 64'(0));
    tick();
    chk("s4_refill_write", 64'(if8.we), 64'(5'h1F));

    // reset while in POST with a sample present
    go_idle();
    if8.decimator = 4'd0; if8.trig_pos = 3'd6; if8.ch_en = 5'h1F;
    if8.smpl_vld = 1; if8.run = 1;
    tick(); tick(); tick();
    chk("s6_armed", 64'(if8.armed), 64'(1));
    if8.triggered = 1;
    tick();
    if8.triggered = 0;
    tick();
    rst8 = 1;
    tick();
    chk("s6_reset_out", 64'({if8.we, if8.waddr, if8.wdata, if8.armed, if8.capture_done, if8.set_capture_done}), 64'(0));
    rst8 = 0;
    tick();
    chk("s6_idle_no_write", 64'(if8.we), 64'(0));
    tick();
    chk("s6_first_write", 64'({if8.we, if8.waddr}), 64'({5'h1F, 3'd0}));

    // randomized capture traffic, checked by the model every cycle
    go_idle();
    if8.run = 1;
    for (int c = 0; c < 2500; c++) begin
      if (if8.run) begin
        if ($urandom_range(0, 59) == 0) if8.run = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        if8.run = 1;
      end
      if8.clr_done  = ($urandom_range(0, 9) == 0);
      if8.triggered = ($urandom_range(0, 7) == 0);
      if8.smpl_vld  = ($urandom_range(0, 3) != 0);
      if8.smpl_data = (NC*DW)'({$urandom(), $urandom()});
      if ($urandom_range(0, 4) == 0) begin
        if8.decimator = 4'($urandom_range(0, 2));
        if8.trig_pos  = 3'($urandom_range(0, 7));
        if8.ch_en     = 5'($urandom());
      end
      rst8 = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst8 = 0;
    go_idle();

    // full-depth ring: 500 stores with ch_en=10101, no trigger
    if384.decimator = 4'd0; if384.trig_pos = 9'd100; if384.ch_en = 5'b10101;
    if384.smpl_vld = 1; if384.run = 1;
    tick();
    for (int k = 0; k < 500; k++) begin
      d = (NC*DW)'({$urandom(), $urandom()});
      if384.smpl_data = d;
      tick();
      chk($sformatf("s5_write%0d", k), 64'({if384.we, if384.waddr, if384.wdata}),
          64'({5'b10101, 9'(k % D384), d}));
      if (k == 282) chk("s5_not_armed", 64'(if384.armed), 64'(0));
      if (k == 283) chk("s5_armed", 64'(if384.armed), 64'(1));
    end
    // trig_pos beyond the ring clamps to DEPTH-1: one store fills the window
    if384.run = 0;
    tick();
    chk("s5_stop_no_write", 64'(if384.we), 64'(0));
    if384.run = 1; if384.trig_pos = 9'd500;
    tick();
    chk("s5_idle_no_write", 64'(if384.we), 64'(0));
    tick();
    chk("s5_clamp_armed", 64'({if384.we, if384.waddr, if384.armed}), 64'({5'b10101, 9'd116, 1'b1}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
